// File: rtl/sub32_pipe.sv
// sub32_pipe: two-stage pipelined 32-bit subtractor (a + ~b + 1) with valid/ready handshakes.
//
// Stage 1 adds the low SPLIT bits and registers the partial difference, the carry into bit
// SPLIT, and the upper operand slices. Stage 2 finishes the upper bits with that carry and
// registers the full result. Outputs come straight from the stage-2 registers.
//
// Parameters:
//   SPLIT       stage-1/stage-2 bit boundary, multiple of 4 in 4..28 (default 16)
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    operand pair offered
//   in_ready    operand pair accepted this cycle
//   in_a/in_b   minuend / subtrahend
//   out_valid   result presented
//   out_ready   consumer takes the result this cycle
//   out_diff    in_a - in_b modulo 2^32
//   out_borrow  1 iff in_a < in_b unsigned
//   out_eq/out_lt/out_ltu  equal, signed less-than, unsigned less-than
// Optional feature macro: SUB32_FLAGS_EN enables the out_eq/out_lt/out_ltu ports and logic.

module sub32_pipe #(
    parameter int unsigned SPLIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_diff,
`ifdef SUB32_FLAGS_EN
    output logic        out_borrow,
    output logic        out_eq,
    output logic        out_lt,
    output logic        out_ltu
`else
    output logic        out_borrow
`endif
);

    localparam int unsigned HiW = 32 - SPLIT;

    // Stage 1 state
    logic             r_s1_valid;
    logic [SPLIT-1:0] r_s1_lo;
    logic             r_s1_carry;
    logic [HiW-1:0]   r_s1_a_hi;
    logic [HiW-1:0]   r_s1_b_hi;

    // Stage 2 state (drives the outputs)
    logic             r_s2_valid;
    logic [31:0]      r_s2_diff;
    logic             r_s2_borrow;

    logic             w_adv1;
    logic             w_adv2;
    logic             w_accept;
    logic [SPLIT:0]   w_lo_sum;
    logic [HiW:0]     w_hi_sum;
    logic [31:0]      w_diff;

    always_comb begin
        w_adv2   = !r_s2_valid || out_ready;
        w_adv1   = !r_s1_valid || w_adv2;
        // Gated by rst so an upstream never sees a handshake that reset will discard.
        in_ready = w_adv1 && !rst;
        w_accept = in_valid && in_ready;
    end

    // Low slice: the "+1" of two's-complement negation enters as the carry-in here.
    always_comb begin
        w_lo_sum = {1'b0, in_a[SPLIT-1:0]} + {1'b0, ~in_b[SPLIT-1:0]}
                 + {{SPLIT{1'b0}}, 1'b1};
    end

    // High slice finishes with the carry registered at the stage boundary.
    always_comb begin
        w_hi_sum = {1'b0, r_s1_a_hi} + {1'b0, ~r_s1_b_hi} + {{HiW{1'b0}}, r_s1_carry};
        w_diff   = {w_hi_sum[HiW-1:0], r_s1_lo};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_lo    <= '0;
            r_s1_carry <= 1'b0;
            r_s1_a_hi  <= '0;
            r_s1_b_hi  <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_lo    <= w_lo_sum[SPLIT-1:0];
                r_s1_carry <= w_lo_sum[SPLIT];
                r_s1_a_hi  <= in_a[31:SPLIT];
                r_s1_b_hi  <= in_b[31:SPLIT];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_diff   <= '0;
            r_s2_borrow <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_diff   <= w_diff;
                r_s2_borrow <= !w_hi_sum[HiW];
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_diff   = r_s2_diff;
    assign out_borrow = r_s2_borrow;

`ifdef SUB32_FLAGS_EN
    logic r_s2_eq;
    logic r_s2_lt;
    logic r_s2_ltu;
    logic w_ovf;

    // Signed overflow: operand signs differ and the result sign differs from the minuend.
    always_comb begin
        w_ovf = (r_s1_a_hi[HiW-1] ^ r_s1_b_hi[HiW-1]) && (w_diff[31] ^ r_s1_a_hi[HiW-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_eq  <= 1'b0;
            r_s2_lt  <= 1'b0;
            r_s2_ltu <= 1'b0;
        end else if (w_adv2 && r_s1_valid) begin
            r_s2_eq  <= (w_diff == 32'd0);
            r_s2_lt  <= w_diff[31] ^ w_ovf;
            r_s2_ltu <= !w_hi_sum[HiW];
        end
    end

    assign out_eq  = r_s2_eq;
    assign out_lt  = r_s2_lt;
    assign out_ltu = r_s2_ltu;
`endif

endmodule

// File: tb/tb_sub32_pipe.sv
// Self-checking bench for sub32_pipe: vector table streamed through a scoreboard plus
// hand-written latency, stall and reset sequences.

module tb_sub32_pipe;

    typedef struct {
        logic [31:0] diff;
        logic        borrow;
        logic        eq;
        logic        lt;
        logic        ltu;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        res_t        r;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_diff;
    logic        out_borrow;
    logic        out_eq;
    logic        out_lt;
    logic        out_ltu;

    int n_vec  = 0;
    int n_fail = 0;

    res_t exp_next;
    res_t sb[$];

    always #5 clk = ~clk;

    sub32_pipe #(.SPLIT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_diff   (out_diff),
`ifdef SUB32_FLAGS_EN
        .out_borrow (out_borrow),
        .out_eq     (out_eq),
        .out_lt     (out_lt),
        .out_ltu    (out_ltu)
`else
        .out_borrow (out_borrow)
`endif
    );

`ifndef SUB32_FLAGS_EN
    assign out_eq  = 1'b0;
    assign out_lt  = 1'b0;
    assign out_ltu = 1'b0;
`endif

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        res_t r;
        r.diff   = a - b;
        r.borrow = (a < b);
        r.eq     = (a == b);
        r.lt     = ($signed(a) < $signed(b));
        r.ltu    = (a < b);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: push on accept, pop/compare on output transfer; reset flushes in-flight ops.
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("diff", out_diff, e.diff);
                    chk("borrow", {31'd0, out_borrow}, {31'd0, e.borrow});
`ifdef SUB32_FLAGS_EN
                    chk("eq", {31'd0, out_eq}, {31'd0, e.eq});
                    chk("lt", {31'd0, out_lt}, {31'd0, e.lt});
                    chk("ltu", {31'd0, out_ltu}, {31'd0, e.ltu});
`endif
                end
            end
            if (in_valid && in_ready) sb.push_back(exp_next);
        end
    end

    task automatic offer(input logic [31:0] a, input logic [31:0] b, input res_t e);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        exp_next = e;
    endtask

    // Offer and hold until accepted; returns #1 after the accept edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input res_t e,
                        input bit rand_ready);
        bit acc;
        int tries;
        offer(a, b, e);
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            tries++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int cyc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (sb.size() != 0 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        @(negedge clk);
        chk("drain_left", sb.size(), 32'd0);
    endtask

    // Single op into an empty pipe: out_valid must rise exactly two edges after accept.
    task automatic latency_op(input logic [31:0] a, input logic [31:0] b, input res_t e);
        out_ready = 1'b1;
        offer(a, b, e);
        #1;
        chk("lat_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("lat_valid_1", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid_2", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    vec_t vt[8];

    initial begin
        logic [31:0] held_diff;
        logic        held_borrow;
        logic [31:0] ra;
        logic [31:0] rb;

        vt[0] = '{32'h00000005, 32'h00000003, '{32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0}};
        vt[1] = '{32'h00000000, 32'h00000001, '{32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b1}};
        vt[2] = '{32'hDEADBEEF, 32'hDEADBEEF, '{32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0}};
        vt[3] = '{32'h80000000, 32'h00000001, '{32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0}};
        vt[4] = '{32'h00010000, 32'h00000001, '{32'h0000FFFF, 1'b0, 1'b0, 1'b0, 1'b0}};
        vt[5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, '{32'h80000000, 1'b1, 1'b0, 1'b0, 1'b1}};
        vt[6] = '{32'hFFFFFFFF, 32'h00000000, '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0}};
        vt[7] = '{32'h12345678, 32'h00005679, '{32'h1233FFFF, 1'b0, 1'b0, 1'b0, 1'b0}};

        // Reset: nothing accepted while asserted, clean state on release.
        rst = 1'b1;
        in_valid = 1'b1;
        exp_next = model(32'd9, 32'd4);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_diff", out_diff, 32'd0);
        chk("rst_out_borrow", {31'd0, out_borrow}, 32'd0);
        chk("rst_flags", {29'd0, out_eq, out_lt, out_ltu}, 32'd0);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Exact latency with the first vector.
        latency_op(vt[0].a, vt[0].b, vt[0].r);

        // Table streamed back-to-back with out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(vt[i].a, vt[i].b, vt[i].r, 1'b0);
        drain();

        // Random operands with random backpressure.
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = (i % 4 == 0) ? ra : $urandom;
            send(ra, rb, model(ra, rb), 1'b1);
        end
        drain();

        // Stall: two accepts fill the pipe, then in_ready drops and outputs hold.
        out_ready = 1'b0;
        offer(32'd100, 32'd1, model(32'd100, 32'd1));
        @(posedge clk);
        #1;
        offer(32'd200, 32'd2, model(32'd200, 32'd2));
        @(posedge clk);
        #1;
        offer(32'd300, 32'd3, model(32'd300, 32'd3));
        #1;
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        held_diff   = out_diff;
        held_borrow = out_borrow;
        chk("stall_head", held_diff, 32'd99);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk("stall_hold_diff", out_diff, held_diff);
            chk("stall_hold_borrow", {31'd0, out_borrow}, {31'd0, held_borrow});
            chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        // Release: accept, advance and output transfer all on the same edge.
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        offer(32'd400, 32'd4, model(32'd400, 32'd4));
        @(posedge clk);
        #1;
        drain();

        // Reset with two ops in flight: they vanish and the next op is clean.
        out_ready = 1'b0;
        offer(32'h11111111, 32'h1, model(32'h11111111, 32'h1));
        @(posedge clk);
        #1;
        offer(32'h22222222, 32'h2, model(32'h22222222, 32'h2));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_out_diff", out_diff, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        latency_op(32'h00010000, 32'h00000001, model(32'h00010000, 32'h00000001));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/sub32_pipe.md
SUB32_PIPE -- requirements
Module: sub32_pipe

Interface
REQ-001 The block SHALL have parameter SPLIT, default 16: the stage-1/stage-2 bit boundary; legal values are multiples of 4 in 4..28.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand pair is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts the operand pair this cycle.
REQ-006 The block SHALL have ports in_a and in_b, input, 32 bits each: minuend and subtrahend.
REQ-007 The block SHALL have port out_valid, output, 1 bit: the result is presented.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-009 The block SHALL have port out_diff, output, 32 bits: in_a - in_b, modulo 2^32.
REQ-010 The block SHALL have port out_borrow, output, 1 bit: 1 iff in_a < in_b unsigned, i.e. the inverted carry-out of in_a + ~in_b + 1.
REQ-011 The block SHALL have ports out_eq, out_lt and out_ltu, output, 1 bit each, present only under SUB32_FLAGS_EN: equal, signed less-than, and unsigned less-than.

Function
REQ-012 Subtraction SHALL be computed as in_a + ~in_b + 1 across two pipeline stages.
REQ-013 Stage 1 SHALL register diff[SPLIT-1:0], the internal carry at bit SPLIT, and the upper operand slices.
REQ-014 Stage 2 SHALL compute the upper bits using the registered carry, then register the full result.
REQ-015 A transfer SHALL occur on either side only when valid and ready are both 1 in the same cycle.
REQ-016 Stage advance rules SHALL be: adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2; in_ready = adv1.
REQ-017 When out_ready is held at 1, latency SHALL be 2 cycles from the accept edge to out_valid=1, with throughput of 1 operation per cycle.
REQ-018 When out_valid=1 and out_ready=0, every out_* signal SHALL hold stable until the transfer completes.
REQ-019 With both stages full and out_ready=0, in_ready SHALL be 0 and no data SHALL be lost or overwritten.
REQ-020 A simultaneous accept into stage 1, advance into stage 2, and output transfer in one cycle SHALL be legal and preserve order.
REQ-021 Results SHALL leave the block in strict acceptance order, with no duplication or drop.
REQ-022 Operands SHALL be sampled only on the accept edge; later changes to in_a or in_b SHALL have no effect.
REQ-023 in_ready MAY depend combinationally on out_ready; out_valid and out_* SHALL be driven directly from registers.

Reset
REQ-024 With rst=1 at a clock edge, both stage valid bits SHALL clear, so out_valid=0 in the following cycle.
REQ-025 Reset values of registered outputs SHALL be out_diff=0, out_borrow=0, and out_eq=out_lt=out_ltu=0.
REQ-026 in_ready SHALL be 1 in the first cycle after reset is released.
REQ-027 A reset asserted while operations are in flight SHALL discard them, and no stale result SHALL ever appear.
REQ-028 While rst=1, no input SHALL be accepted, regardless of in_valid.

Configuration
REQ-029 With macro SUB32_FLAGS_EN defined, the block SHALL register out_eq = (diff==0), out_ltu = borrow, and out_lt = diff[31] ^ signed-overflow, all in stage 2 alongside out_diff.
REQ-030 With SUB32_FLAGS_EN undefined, the flag ports and their logic SHALL be absent, and out_diff, out_borrow and the timing SHALL remain unchanged.

Verification
REQ-031 The bench SHALL cover: a=5, b=3, out_ready=1 -> out_valid exactly 2 cycles after accept; diff=0x00000002, borrow=0, eq=0, lt=0, ltu=0.
REQ-032 The bench SHALL cover: a=0, b=1 -> diff=0xFFFFFFFF, borrow=1, lt=1, ltu=1; and separately a=b=0xDEADBEEF -> diff=0, eq=1.
REQ-033 The bench SHALL cover: a=0x80000000, b=1 -> diff=0x7FFFFFFF, borrow=0, lt=1 (overflow), ltu=0.
REQ-034 The bench SHALL cover: a=0x00010000, b=1 with SPLIT=16 -> diff=0x0000FFFF, proving the carry crosses the stage boundary.
REQ-035 The bench SHALL cover: four back-to-back ops with out_ready=0 for 3 cycles -> in_ready=0 after 2 accepts, outputs stable while stalled, all 4 results in order with none dropped or duplicated.
REQ-036 The bench SHALL cover: rst=1 for 1 cycle with 2 ops in flight -> out_valid=0 the next cycle, in_ready=1 after release, and the next op returns a correct result after 2 cycles.
